mba_mul_arbiter: RTL and testbench

//  Shares one combinational 8x8 signed radix-4 Booth multiplier (mba8r4) among NREQ requesters.

---
 rtl/mba_pkg.sv | 14 +
 rtl/mba8r4.sv | 39 +++
 rtl/rr_arbiter.sv | 55 +++++
 rtl/mba_mul_arbiter.sv | 128 ++++++++++++
 tb/tb_mba_mul_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mba_pkg.sv
// Shared types for the Booth multiplier arbiter slice.
//   OPW        operand width (signed)
//   PRODW      product width (signed); 8x8 signed products never overflow 16 bits
//   mba_op_t   signed operand type
//   mba_prod_t signed product type
package mba_pkg;

  localparam int OPW   = 8;
  localparam int PRODW = 16;

  typedef logic signed [OPW-1:0]   mba_op_t;
  typedef logic signed [PRODW-1:0] mba_prod_t;

endpackage

// File: rtl/mba8r4.sv
// Combinational 8x8 signed radix-4 Booth multiplier.
// Ports:
//   x_i  in   signed multiplicand
//   y_i  in   signed multiplier (Booth-recoded)
//   z_o  out  signed product x_i*y_i, 16-bit two's complement
module mba8r4
  import mba_pkg::*;
(
  input  mba_op_t   x_i,
  input  mba_op_t   y_i,
  output mba_prod_t z_o
);

  logic [OPW:0] yext;
  mba_prod_t    xext;
  mba_prod_t    pp;
  mba_prod_t    acc;

  always_comb begin
    yext = {y_i, 1'b0};
    xext = {{(PRODW-OPW){x_i[OPW-1]}}, x_i};
    pp   = '0;
    acc  = '0;
    // Each overlapping triplet {y[2i+1], y[2i], y[2i-1]} selects a digit in -2..+2.
    for (int i = 0; i < OPW/2; i++) begin
      case (yext[2*i +: 3])
        3'b001, 3'b010: pp = xext;
        3'b011:         pp = xext <<< 1;
        3'b100:         pp = -(xext <<< 1);
        3'b101, 3'b110: pp = -xext;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2*i));
    end
  end

  assign z_o = acc;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an owned rotating priority pointer.
// Ports:
//   clk_i        in   clock
//   rst_n_i      in   async active-low reset (pointer -> 0)
//   req_i        in   request vector
//   advance_i    in   downstream can take a request this cycle
//   grant_o      out  one-hot grant, zero when no request or no advance
//   grant_idx_o  out  index of the winning request (0 when none)
//   grant_vld_o  out  a request is accepted this cycle
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            advance_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o,
  output logic            grant_vld_o
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW:0]   cand;
  logic           found;

  always_comb begin
    found       = 1'b0;
    grant_idx_o = '0;
    grant_o     = '0;
    cand        = '0;
    // Scan from the pointer and wrap; first requester seen wins.
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && req_i[cand[IDW-1:0]]) begin
        found       = 1'b1;
        grant_idx_o = cand[IDW-1:0];
      end
    end
    if (found) grant_o[grant_idx_o] = advance_i;
    grant_vld_o = found & advance_i;

    ptr_d = ptr_q;
    if (grant_vld_o) begin
      ptr_d = (grant_idx_o == IDW'(NREQ-1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mba_mul_arbiter.sv
// Shares one combinational Booth multiplier among NREQ requesters. A round-robin
// arbiter picks one request per cycle; the product is registered and returned with
// the requester ID on a single valid/ready response channel.
// Optional build macro: MBA_ARB_PIPE_EN adds an operand register stage in front of
// the multiplier (latency 2 instead of 1, full throughput kept).
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   async active-low reset
//   req_valid  in   per-requester operand valid
//   req_ready  out  one-hot/zero accept strobe
//   req_x      in   signed multiplicands, requester i at [8i+7:8i]
//   req_y      in   signed multipliers,   requester i at [8i+7:8i]
//   rsp_valid  out  response slot full
//   rsp_ready  in   consumer takes response
//   rsp_z      out  signed product
//   rsp_id     out  requester index of this product
module mba_mul_arbiter
  import mba_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_x,
  input  logic [NREQ*8-1:0] req_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PRODW-1:0]  rsp_z,
  output logic [IDW-1:0]    rsp_id
);

  logic            adv;
  logic            arb_adv;
  logic            accept;
  logic [IDW-1:0]  gidx;
  mba_op_t         sel_x, sel_y;
  mba_op_t         mul_x, mul_y;
  mba_prod_t       prod;
  logic            stage_valid;
  logic [IDW-1:0]  stage_id;

  logic            out_valid_q;
  mba_prod_t       out_z_q;
  logic [IDW-1:0]  out_id_q;

  assign adv   = ~out_valid_q | rsp_ready;
  assign sel_x = req_x[{gidx, 3'b000} +: OPW];
  assign sel_y = req_y[{gidx, 3'b000} +: OPW];

`ifdef MBA_ARB_PIPE_EN
  logic           s1_valid_q;
  mba_op_t        s1_x_q, s1_y_q;
  logic [IDW-1:0] s1_id_q;

  // s1 refills when empty or when its content moves to the output this cycle.
  assign arb_adv = (~s1_valid_q | adv) & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_id_q    <= '0;
    end else if (arb_adv) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_x_q  <= sel_x;
        s1_y_q  <= sel_y;
        s1_id_q <= gidx;
      end
    end
  end

  assign mul_x       = s1_x_q;
  assign mul_y       = s1_y_q;
  assign stage_valid = s1_valid_q;
  assign stage_id    = s1_id_q;
`else
  // Gate with rst_n so nothing reads as accepted while reset is held.
  assign arb_adv     = adv & rst_n;
  assign mul_x       = sel_x;
  assign mul_y       = sel_y;
  assign stage_valid = accept;
  assign stage_id    = gidx;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_i       (req_valid),
    .advance_i   (arb_adv),
    .grant_o     (req_ready),
    .grant_idx_o (gidx),
    .grant_vld_o (accept)
  );

  mba8r4 u_mul (
    .x_i (mul_x),
    .y_i (mul_y),
    .z_o (prod)
  );

  // Output slot: z/id only load with a real product, so a plain drain keeps them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_id_q    <= '0;
    end else if (adv) begin
      out_valid_q <= stage_valid;
      if (stage_valid) begin
        out_z_q  <= prod;
        out_id_q <= stage_id;
      end
    end
  end

  assign rsp_valid = out_valid_q;
  assign rsp_z     = out_z_q;
  assign rsp_id    = out_id_q;

endmodule

// File: tb/tb_mba_mul_arbiter.sv
module tb_mba_mul_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_x;
  logic [NREQ*8-1:0] req_y;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_z;
  logic [IDW-1:0]    rsp_id;

  mba_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    z;
  } exp_t;

  exp_t sbq[$];

  // Reference model state (independent round-robin + single output slot)
  logic m_valid;
  int   m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Model: predict grant and slot occupancy, push expected product on accept.
  always @(negedge clk) begin
    if (rst_n) begin
      bit               m_adv;
      bit               m_found;
      int               g;
      int               cand;
      logic [NREQ-1:0]  m_rdy;
      logic signed [7:0] xs, ys;
      int               p;
      exp_t             e;
      m_adv   = !m_valid || rsp_ready;
      m_found = 0;
      g       = 0;
      for (int k = 0; k < NREQ; k++) begin
        cand = (m_ptr + k) % NREQ;
        if (!m_found && req_valid[cand]) begin
          m_found = 1;
          g       = cand;
        end
      end
      m_rdy = '0;
      if (m_adv && m_found) m_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(m_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_adv) begin
        if (m_found) begin
          xs   = req_x[8*g +: 8];
          ys   = req_y[8*g +: 8];
          p    = int'(xs) * int'(ys);
          e.id = g[IDW-1:0];
          e.z  = p[15:0];
          sbq.push_back(e);
          m_ptr = (g + 1) % NREQ;
        end
        m_valid = m_found;
      end
    end
  end

  // Monitor: whenever a response is taken, compare against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      exp_t e;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_rsp actual_id=%0d actual_z=%0h required=none", rsp_id, rsp_z);
      end else begin
        e = sbq.pop_front();
        check("rsp_z", 32'(rsp_z), 32'(e.z));
        check("rsp_id", 32'(rsp_id), 32'(e.id));
      end
    end
  end

  task automatic drive_one(input int i, input logic [7:0] x, input logic [7:0] y);
    req_valid           = '0;
    req_valid[i]        = 1'b1;
    req_x[8*i +: 8]     = x;
    req_y[8*i +: 8]     = y;
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  logic [15:0]    cap_z;
  logic [IDW-1:0] cap_id;

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;
    m_valid   = 1'b0;
    m_ptr     = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_z", 32'(rsp_z), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst_n     = 1'b1;
    @(posedge clk); #1;

    // Corner products, hand values
    drive_one(0, 8'h80, 8'h80);
    @(negedge clk);
    check("dir_min_min_valid", 32'(rsp_valid), 32'd1);
    check("dir_min_min_z", 32'(rsp_z), 32'h4000);
    check("dir_min_min_id", 32'(rsp_id), 32'd0);
    @(posedge clk); #1;
    drive_one(1, 8'h7F, 8'h80);
    @(negedge clk);
    check("dir_max_min_z", 32'(rsp_z), 32'hC080);
    check("dir_max_min_id", 32'(rsp_id), 32'd1);
    @(posedge clk); #1;

    // Pointer now 2; only req0 and req3 valid -> 3 then 0
    req_valid       = 4'b1001;
    req_x[7:0]      = 8'd3;
    req_y[7:0]      = 8'd5;
    req_x[31:24]    = 8'hFF;
    req_y[31:24]    = 8'hFF;
    @(negedge clk);
    check("rr_wrap_grant3", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    @(negedge clk);
    check("rr_wrap_grant0", 32'(req_ready), 32'b0001);
    check("dir_neg1_z", 32'(rsp_z), 32'h0001);
    check("dir_neg1_id", 32'(rsp_id), 32'd3);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("dir_3x5_z", 32'(rsp_z), 32'h000F);
    check("dir_3x5_id", 32'(rsp_id), 32'd0);

    // Mid-stream async reset
    @(posedge clk); #1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      req_x[8*i +: 8] = 8'(i + 1);
      req_y[8*i +: 8] = 8'hFE;
    end
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    sbq.delete();
    m_valid = 1'b0;
    m_ptr   = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_grant", 32'(req_ready), 32'b0001);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("seq_valid", 32'(rsp_valid), 32'd1);
      check("seq_id", 32'(rsp_id), 32'(k % NREQ));
    end

    // Back-pressure for 5 cycles with the slot full
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    cap_z  = rsp_z;
    cap_id = rsp_id;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_z", 32'(rsp_z), 32'(cap_z));
      check("stall_id", 32'(rsp_id), 32'(cap_id));
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      req_valid = NREQ'($urandom);
      req_x     = $urandom;
      req_y     = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end

    // Drain
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    check("drain_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
